// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial add/subtract unit.
// Nibble width, FSM state encoding and the result flag bundle.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit adder slice with carry-in, carry-out and
// the carry into bit 3 (needed for signed overflow on the top nibble).
module nibble_adder_slice
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [3:0] lo;
  logic [1:0] hi;

  // Low three bits first so the carry into bit 3 is exposed.
  assign lo = {1'b0, x[2:0]}
            + {1'b0, y[2:0]}
            + {3'b000, cin};
  assign c3 = lo[3];

  assign hi = {1'b0, x[3]}
            + {1'b0, y[3]}
            + {1'b0, c3};

  assign s    = {hi[0], lo[2:0]};
  assign cout = hi[1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one nibble per cycle, LSB first.
// Optional signed saturation on overflow: define ADDSUB_SATURATE_EN.
module nibble_serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8)
    begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic             sub_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  flags_t           flags_q;

  logic [NIBBLE_W-1:0] s;
  logic                cout;
  logic                c3;
  logic                last;
  logic                msb_cin;
  logic [WIDTH-1:0]    res_nx;
  logic [WIDTH-1:0]    res_fin;
  flags_t              flags_nx;

  nibble_adder_slice u_slice (
    .x   (a_sh[NIBBLE_W-1:0]),
    .y   (b_sh[NIBBLE_W-1:0]
          ^ {NIBBLE_W{sub_q}}),
    .cin (carry_q),
    .s   (s),
    .cout(cout),
    .c3  (c3)
  );

  assign last    = (cnt_q == CNT_W'(NIBBLES - 1));
  assign msb_cin = c3;
  assign res_nx  = {s, res_q[WIDTH-1:NIBBLE_W]};

`ifdef ADDSUB_SATURATE_EN
  // Both effective operands share a sign on overflow; a's MSB picks it.
  always_comb begin
    res_fin = res_nx;
    if (msb_cin ^ cout) begin
      res_fin = a_sh[NIBBLE_W-1]
        ? {1'b1, {(WIDTH-1){1'b0}}}
        : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_fin = res_nx;
`endif

  always_comb begin
    flags_nx.c = cout;
    flags_nx.z = ~|res_fin;
    flags_nx.v = msb_cin ^ cout;
    flags_nx.n = res_fin[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start_valid) state_nx = RUN;
      RUN:
        if (last) state_nx = DONE;
      DONE:
        if (done_ready) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            sub_q   <= sub;
            carry_q <= sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          carry_q <= cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last) begin
            res_q   <= res_fin;
            flags_q <= flags_nx;
          end else begin
            res_q   <= res_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign result      = res_q;
  assign carry_out   = flags_q.c;
  assign zero        = flags_q.z;
  assign overflow    = flags_q.v;
  assign negative    = flags_q.n;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub (WIDTH=16).
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        done_valid;
  logic        done_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        zero;
  logic        overflow;
  logic        negative;

  int n_chk;
  int n_fail;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .result     (result),
    .carry_out  (carry_out),
    .zero       (zero),
    .overflow   (overflow),
    .negative   (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation; lat = cycles from accept edge to done_valid.
  task automatic do_op(input logic [15:0] ia,
                       input logic [15:0] ib,
                       input logic isub,
                       output int lat);
    int k;
    @(negedge clk);
    a = ia;
    b = ib;
    sub = isub;
    start_valid = 1'b1;
    k = 0;
    while (!start_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop();
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({start_ready, done_valid, result,
         carry_out, zero, overflow, negative}
        !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b dv=%b res=%h f=%b%b%b%b want rdy=1 dv=0 res=0000 f=0000",
               start_ready, done_valid, result,
               carry_out, zero, overflow, negative);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_op(input string name,
                         input logic [15:0] ia,
                         input logic [15:0] ib,
                         input logic isub,
                         input logic [15:0] exp_res,
                         input logic [3:0] exp_f);
    int lat;
    do_op(ia, ib, isub, lat);
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL %s_latency got %0d want 4", name, lat);
    end
    n_chk++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s_result got %h want %h",
               name, result, exp_res);
    end
    n_chk++;
    if ({carry_out, zero, overflow, negative} !== exp_f) begin
      n_fail++;
      $display("FAIL %s_flags got CZVN=%b%b%b%b want %b",
               name, carry_out, zero, overflow, negative, exp_f);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(16'h0001, 16'h0002, 1'b0, lat);
    n_chk++;
    if (result !== 16'h0003 || lat !== 4) begin
      n_fail++;
      $display("FAIL bp_first got res=%h lat=%0d want 0003 lat=4",
               result, lat);
    end
    a = 16'h0010;
    b = 16'h0001;
    sub = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({done_valid, start_ready, result,
           carry_out, zero, overflow, negative}
          !== {1'b1, 1'b0, 16'h0003, 4'b0000}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got dv=%b rdy=%b res=%h want dv=1 rdy=0 res=0003",
                 i, done_valid, start_ready, result);
      end
    end
    pop();
    n_chk++;
    if ({start_ready, done_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_idle got rdy=%b dv=%b want rdy=1 dv=0",
               start_ready, done_valid);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n_chk++;
    if (start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept got rdy=%b want 0", start_ready);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done_valid) begin
        lat = i;
        break;
      end
    end
    n_chk++;
    if (result !== 16'h0011 || lat !== 4) begin
      n_fail++;
      $display("FAIL bp_second got res=%h lat=%0d want 0011 lat=4",
               result, lat);
    end
    pop();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({done_valid, result, carry_out, zero, overflow, negative}
        !== {1'b0, 16'h0000, 4'b0000}) begin
      n_fail++;
      $display("FAIL rst_async got dv=%b res=%h f=%b%b%b%b want dv=0 res=0000 f=0000",
               done_valid, result,
               carry_out, zero, overflow, negative);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %b want 1", start_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_valid) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rst_no_pulse got %0d done cycles want 0", seen);
    end
    test_op("after_rst", 16'h00FF, 16'h0001, 1'b0,
            16'h0100, 4'b0000);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    test_reset();
    test_op("add", 16'h1234, 16'h0FFF, 1'b0,
            16'h2233, 4'b0000);
    test_op("sub_zero", 16'h0005, 16'h0005, 1'b1,
            16'h0000, 4'b1100);
`ifdef ADDSUB_SATURATE_EN
    test_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0,
            16'h7FFF, 4'b0010);
`else
    test_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0,
            16'h8000, 4'b0011);
`endif
    test_op("sub_neg", 16'h0003, 16'h0005, 1'b1,
            16'hFFFE, 4'b0001);
`ifdef ADDSUB_SATURATE_EN
    test_op("sub_ovf", 16'h8000, 16'h0001, 1'b1,
            16'h8000, 4'b1011);
`else
    test_op("sub_ovf", 16'h8000, 16'h0001, 1'b1,
            16'h7FFF, 4'b1010);
`endif
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
